hazard_scoreboard: RTL and testbench

Parametrised successor to the pipeline hazard unit. It tracks in-flight register writes in an internal scoreboard instead of reading per-stage wsel/RegWr buses. It produces:
- stall and flush controls;
- per-operand forwarding selects;
- a squash sequencer for taken control transfers.

It sits beside the ID stage of the MIPS pipeline and drives the IF/ID and ID/EX latch enables and flushes.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_match.sv | 32 +++
 rtl/hazard_scoreboard.sv | 149 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the scoreboard-based hazard unit.
// Scoreboard entries store the destination index in a fixed 8-bit field.
// NREGS can therefore go up to 256. Smaller indices are zero-extended on entry.
package hazard_pkg;

    localparam int NREGS_DEFAULT   = 32;
    localparam int NSTAGES_DEFAULT = 3;
    localparam int SB_REG_W        = 8;

    // One in-flight register write tracked after ID.
    typedef struct packed {
        logic                valid;
        logic [SB_REG_W-1:0] wsel;
        logic                load;
    } sb_entry_t;

    typedef enum logic [1:0] {
        RUN,
        SQUASH,
        HALT
    } hz_state_t;

endpackage

// File: rtl/hazard_match.sv
// Priority encoder: finds the youngest scoreboard entry that writes operand r.
// Register 0 never matches because it is hardwired to zero.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int NSTAGES = NSTAGES_DEFAULT,
    parameter int REG_W   = 5,
    parameter int IDX_W   = (NSTAGES > 1) ? $clog2(NSTAGES) : 1
) (
    input  sb_entry_t [NSTAGES-1:0] sb,
    input  logic      [REG_W-1:0]   r,
    output logic                    hit,
    output logic      [IDX_W-1:0]   k,
    output logic                    load
);

    // Scan oldest to youngest so the lowest matching index is the one left standing.
    always_comb begin
        // NOTE: every output gets a default first, otherwise the no-match path infers latches.
        hit  = 1'b0;
        k    = '0;
        load = 1'b0;
        for (int i = NSTAGES - 1; i >= 0; i--) begin
            if (r != '0 && sb[i].valid && sb[i].wsel == SB_REG_W'(r)) begin
                hit  = 1'b1;
                k    = IDX_W'(i);
                load = sb[i].load;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the MIPS pipeline, sitting beside ID.
// It tracks in-flight register writes in a shifting scoreboard.
// From that it derives forwarding selects and RAW stalls.
// A small FSM squashes wrong-path fetches after a taken transfer and freezes the core on halt.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREGS        = NREGS_DEFAULT,
    parameter int REG_W        = $clog2(NREGS),
    parameter int NSTAGES      = NSTAGES_DEFAULT,
    parameter int FWD_EN       = 1,
    parameter int LOAD_READY   = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int SEL_W        = $clog2(NSTAGES + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dmem_req,
    input  logic             dhit,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_wsel,
    input  logic             id_regwr,
    input  logic             id_load,
    input  logic             xfer_taken,
    input  logic             halt,
    output logic             if_stall,
    output logic             id_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic [SEL_W-1:0] fwd_rs_sel,
    output logic [SEL_W-1:0] fwd_rt_sel,
    output logic             halted
);

    localparam int IDX_W = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

    sb_entry_t [NSTAGES-1:0] sb;
    hz_state_t               state;
    logic      [1:0]         cnt;

    logic             mem_wait;
    logic             advance;
    logic             flush;
    logic             rs_hit;
    logic             rs_load;
    logic [IDX_W-1:0] rs_k;
    logic             rt_hit;
    logic             rt_load;
    logic [IDX_W-1:0] rt_k;
    logic             rs_raw;
    logic             rt_raw;
    logic             raw_stall;
    logic             issue;

    hazard_match #(.NSTAGES(NSTAGES), .REG_W(REG_W), .IDX_W(IDX_W)) u_match_rs (
        .sb   (sb),
        .r    (id_rs),
        .hit  (rs_hit),
        .k    (rs_k),
        .load (rs_load)
    );

    hazard_match #(.NSTAGES(NSTAGES), .REG_W(REG_W), .IDX_W(IDX_W)) u_match_rt (
        .sb   (sb),
        .r    (id_rt),
        .hit  (rt_hit),
        .k    (rt_k),
        .load (rt_load)
    );

    assign mem_wait = dmem_req & ~dhit;
    assign halted   = (state == HALT);
    assign advance  = ihit & ~mem_wait & ~halted;

    // Resolve each operand to a forward select or a RAW stall.
    // Load data is usable only from LOAD_READY onward.
    always_comb begin
        rs_raw     = rs_hit && (FWD_EN == 0 || (rs_load && int'(rs_k) < LOAD_READY));
        rt_raw     = rt_hit && (FWD_EN == 0 || (rt_load && int'(rt_k) < LOAD_READY));
        fwd_rs_sel = (rs_hit && !rs_raw) ? SEL_W'(rs_k) + SEL_W'(1) : '0;
        fwd_rt_sel = (rt_hit && !rt_raw) ? SEL_W'(rt_k) + SEL_W'(1) : '0;
        raw_stall  = rs_raw | rt_raw;
    end

    // Stall/flush priority is halt > mem_wait > flush > raw.
    // A flushed ID instruction never stalls.
    always_comb begin
        flush    = (xfer_taken && state == RUN) || state == SQUASH;
        id_stall = (raw_stall && !flush && !halted) || mem_wait || halted;
        if_stall = id_stall | ~ihit;
        if_flush = flush;
        id_flush = flush;
        issue    = id_valid && id_regwr && (id_wsel != '0) && !id_stall && !flush;
    end

    // Shift the scoreboard on every advancing cycle.
    // The ID write enters only if it really issues; otherwise a bubble enters.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            // NOTE: the whole scoreboard is reset; a stale valid bit would create phantom hazards.
            sb <= '0;
        end else if (advance) begin
            for (int i = 1; i < NSTAGES; i++) begin
                // NOTE: non-blocking so every stage reads the pre-edge value of its neighbour.
                sb[i] <= sb[i-1];
            end
            if (issue) begin
                sb[0] <= '{valid: 1'b1, wsel: SB_REG_W'(id_wsel), load: id_load};
            end else begin
                sb[0] <= '0;
            end
        end
    end

    // Squash sequencer: extends the flush over FLUSH_CYCLES advancing cycles.
    // Halt is sticky until reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= RUN;
            cnt   <= '0;
        end else if (halt) begin
            state <= HALT;
        end else begin
            case (state)
                RUN: begin
                    if (advance && xfer_taken && FLUSH_CYCLES > 1) begin
                        state <= SQUASH;
                        cnt   <= 2'(FLUSH_CYCLES - 2);
                    end
                end
                SQUASH: begin
                    if (advance) begin
                        if (cnt == '0) begin
                            state <= RUN;
                        end else begin
                            cnt <= cnt - 2'd1;
                        end
                    end
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
// Instance a forwards (FLUSH_CYCLES=2); instance b has forwarding disabled (FLUSH_CYCLES=1).
// Both instances see the same inputs.
// Stimulus pushes a hand-computed expectation per cycle.
// A monitor pops it and compares on the falling edge.
module tb_hazard_scoreboard;

    logic       clk;
    logic       n_rst;
    logic       ihit;
    logic       dmem_req;
    logic       dhit;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_wsel;
    logic       id_regwr;
    logic       id_load;
    logic       xfer_taken;
    logic       halt;

    logic       a_if_stall, a_id_stall, a_if_flush, a_id_flush, a_halted;
    logic [1:0] a_rs_sel, a_rt_sel;
    logic       b_if_stall, b_id_stall, b_if_flush, b_id_flush, b_halted;
    logic [1:0] b_rs_sel, b_rt_sel;

    typedef struct {
        string      name;
        bit         dut;
        logic [8:0] v;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    hazard_scoreboard #(.FWD_EN(1), .LOAD_READY(2), .FLUSH_CYCLES(2)) u_a (
        .CLK(clk), .nRST(n_rst), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel),
        .id_regwr(id_regwr), .id_load(id_load), .xfer_taken(xfer_taken), .halt(halt),
        .if_stall(a_if_stall), .id_stall(a_id_stall), .if_flush(a_if_flush),
        .id_flush(a_id_flush), .fwd_rs_sel(a_rs_sel), .fwd_rt_sel(a_rt_sel),
        .halted(a_halted)
    );

    hazard_scoreboard #(.FWD_EN(0), .LOAD_READY(2), .FLUSH_CYCLES(1)) u_b (
        .CLK(clk), .nRST(n_rst), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel),
        .id_regwr(id_regwr), .id_load(id_load), .xfer_taken(xfer_taken), .halt(halt),
        .if_stall(b_if_stall), .id_stall(b_id_stall), .if_flush(b_if_flush),
        .id_flush(b_id_flush), .fwd_rs_sel(b_rs_sel), .fwd_rt_sel(b_rt_sel),
        .halted(b_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector layout: {if_stall, id_stall, if_flush, id_flush, rs_sel, rt_sel, halted}
    task automatic expect_out(input string name, input bit dut, input logic ifs, input logic ids,
                              input logic fl, input logic [1:0] rs, input logic [1:0] rt,
                              input logic h);
        exp_t e;
        e.name = name;
        e.dut  = dut;
        e.v    = {ifs, ids, fl, fl, rs, rt, h};
        q.push_back(e);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] ws, input logic rw, input logic ld);
        id_valid = v;
        id_rs    = rs;
        id_rt    = rt;
        id_wsel  = ws;
        id_regwr = rw;
        id_load  = ld;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare one queued expectation per cycle, mid-period.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [8:0] act;
            e   = q.pop_front();
            act = e.dut ? {b_if_stall, b_id_stall, b_if_flush, b_id_flush, b_rs_sel, b_rt_sel, b_halted}
                        : {a_if_stall, a_id_stall, a_if_flush, a_id_flush, a_rs_sel, a_rt_sel, a_halted};
            vectors++;
            if (act !== e.v) begin
                miscompares++;
                $display("FAIL %s (dut %0d): got %b expected %b", e.name, e.dut, act, e.v);
            end
        end
    end

    initial begin
        n_rst      = 1'b0;
        ihit       = 1'b1;
        dmem_req   = 1'b0;
        dhit       = 1'b0;
        xfer_taken = 1'b0;
        halt       = 1'b0;
        set_id(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Reset state with idle inputs.
        expect_out("reset_idle", 0, 0, 0, 0, 0, 0, 0); step();

        // ALU producer forwarded from EX, MEM, WB, then gone.
        set_id(1, 1, 2, 3, 1, 0); expect_out("add3_issue", 0, 0, 0, 0, 0, 0, 0); step();
        set_id(1, 3, 0, 0, 0, 0); expect_out("fwd_rs_k0", 0, 0, 0, 0, 1, 0, 0); step();
        expect_out("fwd_rs_k1", 0, 0, 0, 0, 2, 0, 0); step();
        expect_out("fwd_rs_k2", 0, 0, 0, 0, 3, 0, 0); step();
        expect_out("fwd_rs_clear", 0, 0, 0, 0, 0, 0, 0); step();

        // Load-use: stall while k < LOAD_READY, then forward from WB.
        set_id(1, 1, 0, 4, 1, 1); expect_out("lw4_issue", 0, 0, 0, 0, 0, 0, 0); step();
        set_id(1, 0, 4, 0, 0, 0); expect_out("load_stall_k0", 0, 1, 1, 0, 0, 0, 0); step();
        expect_out("load_stall_k1", 0, 1, 1, 0, 0, 0, 0); step();
        expect_out("load_fwd_k2", 0, 0, 0, 0, 0, 3, 0); step();

        // Forwarding disabled: stall for three advances until the write leaves.
        set_id(1, 0, 0, 6, 1, 0); expect_out("b_add6_issue", 1, 0, 0, 0, 0, 0, 0); step();
        set_id(1, 6, 0, 0, 0, 0); expect_out("b_raw_k0", 1, 1, 1, 0, 0, 0, 0); step();
        expect_out("b_raw_k1", 1, 1, 1, 0, 0, 0, 0); step();
        expect_out("b_raw_k2", 1, 1, 1, 0, 0, 0, 0); step();
        expect_out("b_raw_clear", 1, 0, 0, 0, 0, 0, 0); step();

        // Two writes to $5: youngest wins. Then $0 never matches.
        set_id(1, 0, 0, 5, 1, 0); expect_out("y_w5_first", 0, 0, 0, 0, 0, 0, 0); step();
        expect_out("y_w5_second", 0, 0, 0, 0, 0, 0, 0); step();
        set_id(1, 5, 5, 0, 0, 0); expect_out("youngest_wins", 0, 0, 0, 0, 1, 1, 0); step();
        set_id(1, 0, 0, 0, 1, 0); expect_out("r0_no_match", 0, 0, 0, 0, 0, 0, 0); step();
        set_id(1, 0, 5, 0, 0, 0); expect_out("r0_bubble_rt5_k2", 0, 0, 0, 0, 0, 3, 0); step();

        // Data-memory wait freezes the scoreboard; selects stay valid.
        set_id(1, 0, 0, 7, 1, 0); expect_out("m_w7_issue", 0, 0, 0, 0, 0, 0, 0); step();
        dmem_req = 1'b1;
        dhit     = 1'b0;
        set_id(1, 7, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            expect_out("mem_wait", 0, 1, 1, 0, 1, 0, 0); step();
        end
        dhit = 1'b1;
        expect_out("mem_done", 0, 0, 0, 0, 1, 0, 0); step();
        dmem_req = 1'b0;
        dhit     = 1'b0;
        expect_out("mem_shift_once", 0, 0, 0, 0, 2, 0, 0); step();
        set_id(0, 0, 0, 0, 0, 0); expect_out("m_drain", 0, 0, 0, 0, 0, 0, 0); step();

        // Taken transfer over a load-use hazard: two flush cycles, no stall, only bubbles enter.
        set_id(1, 0, 0, 8, 1, 1); expect_out("f_lw8_issue", 0, 0, 0, 0, 0, 0, 0); step();
        xfer_taken = 1'b1;
        set_id(1, 8, 0, 9, 1, 0); expect_out("flush_taken", 0, 0, 0, 1, 0, 0, 0); step();
        expect_out("flush_squash_xfer_ignored", 0, 0, 0, 1, 0, 0, 0); step();
        xfer_taken = 1'b0;
        set_id(1, 9, 8, 0, 0, 0); expect_out("flush_done_no_9", 0, 0, 0, 0, 0, 3, 0); step();

        // Fetch miss holds IF only.
        set_id(0, 0, 0, 0, 0, 0);
        ihit = 1'b0;
        expect_out("ihit_low", 0, 1, 0, 0, 0, 0, 0); step();
        ihit = 1'b1;

        // Reset taken in the middle of a squash.
        xfer_taken = 1'b1;
        expect_out("sq_enter", 0, 0, 0, 1, 0, 0, 0); step();
        xfer_taken = 1'b0;
        n_rst      = 1'b0;
        expect_out("sq_during_reset", 0, 0, 0, 1, 0, 0, 0); step();
        n_rst = 1'b1;
        expect_out("sq_after_reset", 0, 0, 0, 0, 0, 0, 0); step();

        // Halt: effective from the next cycle, sticky, cleared only by reset.
        halt = 1'b1;
        expect_out("halt_seen", 0, 0, 0, 0, 0, 0, 0); step();
        halt       = 1'b0;
        xfer_taken = 1'b1;
        set_id(1, 3, 4, 0, 0, 0);
        expect_out("halted_no_flush", 0, 1, 1, 0, 0, 0, 1); step();
        xfer_taken = 1'b0;
        expect_out("halt_sticky", 0, 1, 1, 0, 0, 0, 1); step();
        n_rst = 1'b0;
        expect_out("halt_reset_edge", 0, 1, 1, 0, 0, 0, 1); step();
        n_rst = 1'b1;
        set_id(1, 8, 7, 0, 0, 0);
        expect_out("post_reset", 0, 0, 0, 0, 0, 0, 0); step();

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
